// File: rtl/scm_read_port_arbiter.sv
// Read-port arbiter for the multi-read-port latch register file.
// Round-robin grants N_REQ requesters onto N_READ file read ports, captures the
// returned word per requester and hands it back over a valid/ready handshake.
module scm_read_port_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned N_READ     = 2,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_REQ-1:0]                      req_i,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]      addr_i,
  output logic [N_REQ-1:0]                      gnt_o,
  output logic [N_REQ-1:0]                      rvalid_o,
  output logic [N_REQ-1:0][DATA_WIDTH-1:0]      rdata_o,
  input  logic [N_REQ-1:0]                      rready_i,
  output logic [N_READ-1:0]                     ReadEnable,
  output logic [N_READ-1:0][ADDR_WIDTH-1:0]     ReadAddr,
  input  logic [N_READ-1:0][DATA_WIDTH-1:0]     ReadData
);

  localparam int unsigned IdW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StInflight, StValid} slot_e;

  slot_e                               slot_q [N_REQ];
  slot_e                               slot_d [N_REQ];
  logic [IdW-1:0]                      rr_ptr_q, rr_ptr_d;
  logic [N_READ-1:0]                   port_vld_q;
  logic [N_READ-1:0][IdW-1:0]          port_id_q, port_id_d;
  logic [N_REQ-1:0][DATA_WIDTH-1:0]    rdata_q;
  logic [N_REQ-1:0]                    eligible;

  // A requester may be granted when idle, or when its response is consumed this cycle.
  always_comb begin
    eligible = '0;
    for (int unsigned r = 0; r < N_REQ; r++) begin
      eligible[r] = req_i[r] &
                    ((slot_q[r] == StIdle) | ((slot_q[r] == StValid) & rready_i[r]));
    end
  end

  // Round-robin scan from rr_ptr; the k-th granted requester is served by port k.
  always_comb begin
    logic [IdW:0]   idx_ext;
    logic [IdW-1:0] idx;
    logic [IdW-1:0] last;
    logic [IdW:0]   nxt;
    logic           any_gnt;
    int unsigned    n_gnt;

    gnt_o      = '0;
    ReadEnable = '0;
    ReadAddr   = '0;
    port_id_d  = '0;
    idx_ext    = '0;
    idx        = '0;
    last       = rr_ptr_q;
    nxt        = '0;
    any_gnt    = 1'b0;
    n_gnt      = 0;

    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx_ext = {1'b0, rr_ptr_q} + (IdW+1)'(i);
      if (idx_ext >= (IdW+1)'(N_REQ)) idx_ext = idx_ext - (IdW+1)'(N_REQ);
      idx = idx_ext[IdW-1:0];
      if (eligible[idx] && (n_gnt < N_READ)) begin
        gnt_o[idx] = 1'b1;
        for (int unsigned k = 0; k < N_READ; k++) begin
          if (k == n_gnt) begin
            ReadEnable[k] = 1'b1;
            ReadAddr[k]   = addr_i[idx];
            port_id_d[k]  = idx;
          end
        end
        n_gnt   = n_gnt + 1;
        any_gnt = 1'b1;
        last    = idx;
      end
    end

    // Nothing leaves the block while reset is asserted.
    if (!rst_n) begin
      gnt_o      = '0;
      ReadEnable = '0;
      ReadAddr   = '0;
      any_gnt    = 1'b0;
    end

    nxt = {1'b0, last} + (IdW+1)'(1);
    if (nxt >= (IdW+1)'(N_REQ)) nxt = '0;
    rr_ptr_d = any_gnt ? nxt[IdW-1:0] : rr_ptr_q;
  end

  // Per-requester slot next state.
  always_comb begin
    for (int unsigned r = 0; r < N_REQ; r++) begin
      slot_d[r] = slot_q[r];
      unique case (slot_q[r])
        StIdle:     if (gnt_o[r]) slot_d[r] = StInflight;
        StInflight: slot_d[r] = StValid;
        StValid:    if (rready_i[r]) slot_d[r] = gnt_o[r] ? StInflight : StIdle;
        default:    slot_d[r] = StIdle;
      endcase
    end
  end

  // State registers; port bookkeeping steers each returned word to its requester.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < N_REQ; r++) slot_q[r] <= StIdle;
      rr_ptr_q   <= '0;
      port_vld_q <= '0;
      port_id_q  <= '0;
      rdata_q    <= '0;
    end else begin
      for (int unsigned r = 0; r < N_REQ; r++) slot_q[r] <= slot_d[r];
      rr_ptr_q   <= rr_ptr_d;
      port_vld_q <= ReadEnable;
      port_id_q  <= port_id_d;
      for (int unsigned k = 0; k < N_READ; k++) begin
        for (int unsigned r = 0; r < N_REQ; r++) begin
          if (port_vld_q[k] && (port_id_q[k] == IdW'(r))) rdata_q[r] <= ReadData[k];
        end
      end
    end
  end

  // Response outputs.
  always_comb begin
    for (int unsigned r = 0; r < N_REQ; r++) rvalid_o[r] = (slot_q[r] == StValid);
    rdata_o = rdata_q;
  end

endmodule

// File: tb/tb_scm_read_port_arbiter.sv
// Self-checking bench for scm_read_port_arbiter with a behavioural register-file stub.
module tb_scm_read_port_arbiter;

  logic                  clk;
  logic                  rst_n;
  logic [3:0]            req_i;
  logic [3:0][4:0]       addr_i;
  logic [3:0]            gnt_o;
  logic [3:0]            rvalid_o;
  logic [3:0][31:0]      rdata_o;
  logic [3:0]            rready_i;
  logic [1:0]            ReadEnable;
  logic [1:0][4:0]       ReadAddr;
  logic [1:0][31:0]      ReadData;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  scm_read_port_arbiter #(
    .N_REQ(4), .N_READ(2), .ADDR_WIDTH(5), .DATA_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .addr_i(addr_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rready_i(rready_i),
    .ReadEnable(ReadEnable), .ReadAddr(ReadAddr), .ReadData(ReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // File contents: word 7 is DEADBEEF, the rest encode their address.
  function automatic logic [31:0] file_word(input logic [4:0] a);
    if (a == 5'd7) return 32'hDEADBEEF;
    return {16'hC0DE, 3'b000, a, 3'b101, a};
  endfunction

  // File stub: address registered on ReadEnable, data presented the next cycle.
  logic [1:0][4:0] raddr_q;
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) if (ReadEnable[k]) raddr_q[k] <= ReadAddr[k];
  end
  always_comb begin
    for (int k = 0; k < 2; k++) ReadData[k] = file_word(raddr_q[k]);
  end

  // Scoreboard: pop on consumed response, push on grant.
  task automatic sb_sample();
    int found;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      for (int r = 0; r < 4; r++) begin
        if (rvalid_o[r] && rready_i[r]) begin
          found = -1;
          for (int i = 0; i < sb_q.size(); i++) if (found < 0 && sb_q[i].id == r) found = i;
          n_tests++;
          if (found < 0) begin
            n_fail++;
            $display("FAIL sb_unexpected req %0d got data %h want no response", r, rdata_o[r]);
          end else begin
            if (rdata_o[r] !== sb_q[found].data) begin
              n_fail++;
              $display("FAIL sb_data req %0d got %h want %h", r, rdata_o[r], sb_q[found].data);
            end
            sb_q.delete(found);
          end
        end
      end
      for (int r = 0; r < 4; r++) begin
        if (gnt_o[r]) sb_q.push_back('{id: r, data: file_word(addr_i[r])});
      end
    end
  endtask

  // Sample the current cycle at negedge, then move to just after the next posedge.
  task automatic step();
    @(negedge clk);
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_i = '0; rready_i = '0; addr_i = '0;
    step(); step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_i = 4'b1111; rready_i = 4'b1111;
    #1;
    n_tests++;
    if (gnt_o !== 4'b0000) begin
      n_fail++; $display("FAIL reset_gnt got %b want %b", gnt_o, 4'b0000);
    end
    n_tests++;
    if (ReadEnable !== 2'b00) begin
      n_fail++; $display("FAIL reset_re got %b want %b", ReadEnable, 2'b00);
    end
    step();
    n_tests++;
    if (rvalid_o !== 4'b0000) begin
      n_fail++; $display("FAIL reset_rvalid got %b want %b", rvalid_o, 4'b0000);
    end
    n_tests++;
    if (rdata_o !== '0) begin
      n_fail++; $display("FAIL reset_rdata got %h want 0", rdata_o);
    end
    rst_n = 1'b1; req_i = '0; rready_i = '0;
    step();
  endtask

  task automatic test_full_contention();
    do_reset();
    rready_i = 4'b1111; req_i = 4'b1111;
    for (int r = 0; r < 4; r++) addr_i[r] = 5'(r + 1);
    #1;
    n_tests++;
    if (gnt_o !== 4'b0011 || ReadEnable !== 2'b11 || ReadAddr[0] !== 5'd1 || ReadAddr[1] !== 5'd2)
    begin
      n_fail++;
      $display("FAIL contention_t0 got gnt %b re %b a0 %0d a1 %0d want 0011 11 1 2",
               gnt_o, ReadEnable, ReadAddr[0], ReadAddr[1]);
    end
    step();
    n_tests++;
    if (gnt_o !== 4'b1100 || ReadAddr[0] !== 5'd3 || ReadAddr[1] !== 5'd4) begin
      n_fail++;
      $display("FAIL contention_t1 got gnt %b a0 %0d a1 %0d want 1100 3 4",
               gnt_o, ReadAddr[0], ReadAddr[1]);
    end
    step();
    n_tests++;
    if (gnt_o !== 4'b0011 || rvalid_o !== 4'b0011) begin
      n_fail++;
      $display("FAIL contention_t2 got gnt %b rvalid %b want 0011 0011", gnt_o, rvalid_o);
    end
    step();
    req_i = '0;
    step(); step(); step();
    n_tests++;
    if (rvalid_o !== 4'b0000) begin
      n_fail++; $display("FAIL contention_drain got rvalid %b want 0000", rvalid_o);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    req_i = 4'b0001; addr_i[0] = 5'd7; rready_i = '0;
    #1;
    n_tests++;
    if (gnt_o !== 4'b0001 || ReadEnable !== 2'b01 || ReadAddr[0] !== 5'd7 || ReadAddr[1] !== 5'd0)
    begin
      n_fail++;
      $display("FAIL single_grant got gnt %b re %b a0 %0d a1 %0d want 0001 01 7 0",
               gnt_o, ReadEnable, ReadAddr[0], ReadAddr[1]);
    end
    step();
    req_i = '0;
    n_tests++;
    if (rvalid_o !== 4'b0000) begin
      n_fail++; $display("FAIL single_t1_rvalid got %b want 0000", rvalid_o);
    end
    step();
    n_tests++;
    if (rvalid_o !== 4'b0001 || rdata_o[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_t2 got rvalid %b data %h want 0001 deadbeef", rvalid_o, rdata_o[0]);
    end
    rready_i[0] = 1'b1;
    step();
    rready_i = '0;
    n_tests++;
    if (rvalid_o !== 4'b0000) begin
      n_fail++; $display("FAIL single_consumed got rvalid %b want 0000", rvalid_o);
    end
  endtask

  task automatic test_wraparound();
    do_reset();
    rready_i = 4'b1111; req_i = 4'b0100; addr_i[2] = 5'd9;
    #1;
    n_tests++;
    if (gnt_o !== 4'b0100) begin
      n_fail++; $display("FAIL wrap_setup got gnt %b want 0100", gnt_o);
    end
    step();
    req_i = '0;
    step(); step();
    // rr_ptr is now 3
    req_i = 4'b1001; addr_i[3] = 5'd11; addr_i[0] = 5'd12;
    #1;
    n_tests++;
    if (gnt_o !== 4'b1001 || ReadAddr[0] !== 5'd11 || ReadAddr[1] !== 5'd12) begin
      n_fail++;
      $display("FAIL wrap_grant got gnt %b a0 %0d a1 %0d want 1001 11 12",
               gnt_o, ReadAddr[0], ReadAddr[1]);
    end
    step();
    req_i = '0;
    step();
    // rr_ptr should be 1: scan starts at requester 1
    req_i = 4'b1111;
    for (int r = 0; r < 4; r++) addr_i[r] = 5'(13 + r);
    #1;
    n_tests++;
    if (gnt_o !== 4'b0110 || ReadAddr[0] !== 5'd14) begin
      n_fail++;
      $display("FAIL wrap_next_ptr got gnt %b a0 %0d want 0110 14", gnt_o, ReadAddr[0]);
    end
    step();
    req_i = '0;
    step(); step(); step();
  endtask

  task automatic test_backpressure();
    logic [31:0] first_word;
    do_reset();
    req_i = 4'b0100; addr_i[2] = 5'd20; rready_i = '0;
    first_word = file_word(5'd20);
    #1;
    n_tests++;
    if (gnt_o !== 4'b0100) begin
      n_fail++; $display("FAIL bp_grant got gnt %b want 0100", gnt_o);
    end
    step(); step();
    addr_i[2] = 5'd21;
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (gnt_o[2] !== 1'b0 || rvalid_o[2] !== 1'b1 || rdata_o[2] !== first_word) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d got gnt %b rvalid %b data %h want 0 1 %h",
                 c, gnt_o[2], rvalid_o[2], rdata_o[2], first_word);
      end
      step();
    end
    rready_i[2] = 1'b1;
    #1;
    n_tests++;
    if (gnt_o[2] !== 1'b1 || ReadAddr[0] !== 5'd21) begin
      n_fail++;
      $display("FAIL bp_release got gnt %b a0 %0d want 1 21", gnt_o[2], ReadAddr[0]);
    end
    step();
    req_i = '0;
    step();
    n_tests++;
    if (rvalid_o[2] !== 1'b1 || rdata_o[2] !== file_word(5'd21)) begin
      n_fail++;
      $display("FAIL bp_new_data got rvalid %b data %h want 1 %h",
               rvalid_o[2], rdata_o[2], file_word(5'd21));
    end
    step();
    rready_i = '0;
  endtask

  task automatic test_inflight_block();
    do_reset();
    req_i = 4'b0010; addr_i[1] = 5'd3; rready_i = 4'b0010;
    #1;
    n_tests++;
    if (gnt_o !== 4'b0010) begin
      n_fail++; $display("FAIL inflight_t0 got gnt %b want 0010", gnt_o);
    end
    step();
    n_tests++;
    if (gnt_o !== 4'b0000) begin
      n_fail++; $display("FAIL inflight_t1 got gnt %b want 0000", gnt_o);
    end
    req_i = '0;
    step(); step();
    rready_i = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_i = 4'b1111; rready_i = 4'b1111;
    for (int r = 0; r < 4; r++) addr_i[r] = 5'(24 + r);
    #1;
    n_tests++;
    if (gnt_o !== 4'b0011) begin
      n_fail++; $display("FAIL rstmid_t0 got gnt %b want 0011", gnt_o);
    end
    step();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (gnt_o !== 4'b0000 || ReadEnable !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_forced got gnt %b re %b want 0000 00", gnt_o, ReadEnable);
    end
    step();
    rst_n = 1'b1; req_i = '0;
    #1;
    n_tests++;
    if (rvalid_o !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_rvalid got %b want 0000", rvalid_o);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if (rvalid_o !== 4'b0000) begin
        n_fail++; $display("FAIL rstmid_stale cycle %0d got rvalid %b want 0000", c, rvalid_o);
      end
    end
    req_i = 4'b1111;
    #1;
    n_tests++;
    if (gnt_o !== 4'b0011) begin
      n_fail++; $display("FAIL rstmid_ptr got gnt %b want 0011", gnt_o);
    end
    step();
    req_i = '0;
    step(); step(); step();
    rready_i = '0;
  endtask

  initial begin
    rst_n = 1'b0; req_i = '0; rready_i = '0; addr_i = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_full_contention();
    test_single_read();
    test_wraparound();
    test_backpressure();
    test_inflight_block();
    test_reset_mid();
    step();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover got %0d pending want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
